// File: rtl/call_ret_pkg.sv
// Shared types and constants for the call/return sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package call_ret_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALL_X = 2'd1,
        RET_X  = 2'd2
    } state_t;

    localparam int DEF_AW    = 8;
    localparam int DEF_DEPTH = 8;

    // Nesting depth runs 0..DEPTH+1 (stack entries plus the link register).
    function automatic int depth_w(input int depth_entries);
        return $clog2(depth_entries + 2);
    endfunction

endpackage

// File: rtl/ras_mem.sv
// Return-address spill stack storage: DEPTH x AW registers, no reset.
// Latency: write lands on the clk edge; read is combinational.
// Backpressure: none; the sequencer only writes/reads valid slots.
// Ports: clk; we/waddr/wdata sync write port; raddr/rdata async read port.
module ras_mem #(
    parameter int AW    = 8,
    parameter int DEPTH = 8,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [AW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [AW-1:0] rdata
);

    logic [AW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_return_ctrl.sv
// Call/return sequencer feeding the link register and PC redirect.
// Latency: request sampled at edge N, strobes high in cycle N..N+1, LR/PC load at N+1.
// Backpressure: ready low during the 1-cycle execute state; requests ignored then.
// Ports: call_req/ret_req/flush requests, pc_in/target_in CALL operands, lr_q link
//        feedback; lr_in/lr_load_en and pc_next/pc_load_en strobes; depth and
//        sticky overflow/underflow status.
module call_return_ctrl
    import call_ret_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH,
    localparam int DW   = depth_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          call_req,
    input  logic          ret_req,
    input  logic          flush,
    input  logic [AW-1:0] pc_in,
    input  logic [AW-1:0] target_in,
    input  logic [AW-1:0] lr_q,
    output logic          ready,
    output logic [AW-1:0] lr_in,
    output logic          lr_load_en,
    output logic [AW-1:0] pc_next,
    output logic          pc_load_en,
    output logic [DW-1:0] depth,
    output logic          overflow,
    output logic          underflow
);

    // sp spans 0..DEPTH; memory index only needs 0..DEPTH-1.
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH + 1);

    state_t          state_q, state_d;
    logic [SPW-1:0]  sp_q, sp_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   tgt_q, tgt_d;

    logic            mem_we;
    logic [AW-1:0]   mem_rdata;

    ras_mem #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_ras_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (IW'(sp_q)),
        .wdata (lr_q),
        .raddr (IW'(sp_q - SPW'(1))),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sp_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            pc_q    <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        depth_d    = depth_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        ready      = 1'b0;
        lr_in      = '0;
        lr_load_en = 1'b0;
        pc_next    = '0;
        pc_load_en = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (flush) begin
                    sp_d    = '0;
                    depth_d = '0;
                end else if (call_req) begin
                    // CALL has priority; a simultaneous RET is dropped.
                    if (depth_q == DEPTH_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        pc_d    = pc_in;
                        tgt_d   = target_in;
                        state_d = CALL_X;
                    end
                end else if (ret_req) begin
                    if (depth_q == '0) begin
                        udf_d = 1'b1;
                    end else begin
                        state_d = RET_X;
                    end
                end
            end

            CALL_X: begin
                lr_in      = pc_q + AW'(1);
                lr_load_en = 1'b1;
                pc_next    = tgt_q;
                pc_load_en = 1'b1;
                // The first frame lives only in the link register; deeper frames
                // spill the outgoing link value on the same edge it is replaced.
                if (depth_q != '0) begin
                    mem_we = 1'b1;
                    sp_d   = sp_q + SPW'(1);
                end
                depth_d = depth_q + DW'(1);
                state_d = IDLE;
                if (flush) begin
                    sp_d    = '0;
                    depth_d = '0;
                end
            end

            RET_X: begin
                pc_next    = lr_q;
                pc_load_en = 1'b1;
                if (sp_q != '0) begin
                    lr_in      = mem_rdata;
                    lr_load_en = 1'b1;
                    sp_d       = sp_q - SPW'(1);
                end
                depth_d = depth_q - DW'(1);
                state_d = IDLE;
                if (flush) begin
                    sp_d    = '0;
                    depth_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign depth     = depth_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl with a behavioural link register.
// Latency: inputs driven #1 after posedge, outputs checked #1 after posedge.
// Backpressure: requests are pulsed for one IDLE cycle only.
module tb_call_return_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       call_req = 1'b0;
    logic       ret_req = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] pc_in = '0;
    logic [7:0] target_in = '0;
    logic [7:0] lr_q = '0;
    logic       ready;
    logic [7:0] lr_in;
    logic       lr_load_en;
    logic [7:0] pc_next;
    logic       pc_load_en;
    logic [3:0] depth;
    logic       overflow;
    logic       underflow;

    int n_cmp = 0;
    int n_fail = 0;

    call_return_ctrl #(.AW(8), .DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .call_req   (call_req),
        .ret_req    (ret_req),
        .flush      (flush),
        .pc_in      (pc_in),
        .target_in  (target_in),
        .lr_q       (lr_q),
        .ready      (ready),
        .lr_in      (lr_in),
        .lr_load_en (lr_load_en),
        .pc_next    (pc_next),
        .pc_load_en (pc_load_en),
        .depth      (depth),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    // Link register outside the DUT.
    always @(posedge clk) begin
        if (lr_load_en) lr_q <= lr_in;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a one-cycle request; returns positioned in the strobe cycle.
    task automatic issue(input logic c, input logic r, input logic [7:0] pc, input logic [7:0] tgt);
        call_req  = c;
        ret_req   = r;
        pc_in     = pc;
        target_in = tgt;
        tick();
        call_req = 1'b0;
        ret_req  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if ({ready, lr_load_en, pc_load_en} !== 3'b100) begin n_fail++; $display("FAIL reset_strobes got %b want 100", {ready, lr_load_en, pc_load_en}); end
        n_cmp++; if ({lr_in, pc_next} !== 16'h0000) begin n_fail++; $display("FAIL reset_data got %h want 0000", {lr_in, pc_next}); end
        n_cmp++; if ({depth, overflow, underflow} !== 6'b0) begin n_fail++; $display("FAIL reset_status got %b want 000000", {depth, overflow, underflow}); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_call();
        issue(1'b1, 1'b0, 8'h10, 8'h40);
        n_cmp++; if (lr_in !== 8'h11) begin n_fail++; $display("FAIL call_lr_in got %h want 11", lr_in); end
        n_cmp++; if (pc_next !== 8'h40) begin n_fail++; $display("FAIL call_pc_next got %h want 40", pc_next); end
        n_cmp++; if ({ready, lr_load_en, pc_load_en} !== 3'b011) begin n_fail++; $display("FAIL call_strobes got %b want 011", {ready, lr_load_en, pc_load_en}); end
        tick();
        n_cmp++; if (depth !== 4'd1) begin n_fail++; $display("FAIL call_depth got %0d want 1", depth); end
        n_cmp++; if (lr_q !== 8'h11) begin n_fail++; $display("FAIL call_lr_q got %h want 11", lr_q); end
        issue(1'b0, 1'b1, 8'h00, 8'h00);
        n_cmp++; if ({pc_next, pc_load_en, lr_load_en, lr_in} !== {8'h11, 1'b1, 1'b0, 8'h00}) begin n_fail++; $display("FAIL single_ret got pc=%h pl=%b ll=%b lr=%h want pc=11 pl=1 ll=0 lr=00", pc_next, pc_load_en, lr_load_en, lr_in); end
        tick();
        n_cmp++; if (depth !== 4'd0) begin n_fail++; $display("FAIL single_ret_depth got %0d want 0", depth); end
    endtask

    task automatic test_nested();
        logic [7:0] exp_pc [3];
        logic [7:0] exp_lr [3];
        logic       exp_ll [3];
        exp_pc = '{8'h31, 8'h21, 8'h11};
        exp_lr = '{8'h21, 8'h11, 8'h00};
        exp_ll = '{1'b1, 1'b1, 1'b0};
        for (int i = 1; i <= 3; i++) begin
            issue(1'b1, 1'b0, 8'(i * 16), 8'(8'h40 + i * 16));
            tick();
        end
        n_cmp++; if (depth !== 4'd3 || lr_q !== 8'h31) begin n_fail++; $display("FAIL nest_calls got depth=%0d lr_q=%h want depth=3 lr_q=31", depth, lr_q); end
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 1'b1, 8'h00, 8'h00);
            n_cmp++; if (pc_next !== exp_pc[i] || pc_load_en !== 1'b1) begin n_fail++; $display("FAIL nest_ret%0d_pc got %h/%b want %h/1", i, pc_next, pc_load_en, exp_pc[i]); end
            n_cmp++; if (lr_in !== exp_lr[i] || lr_load_en !== exp_ll[i]) begin n_fail++; $display("FAIL nest_ret%0d_lr got %h/%b want %h/%b", i, lr_in, lr_load_en, exp_lr[i], exp_ll[i]); end
            tick();
        end
        n_cmp++; if (depth !== 4'd0) begin n_fail++; $display("FAIL nest_depth got %0d want 0", depth); end
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < 9; i++) begin
            issue(1'b1, 1'b0, 8'(8'h80 + i), 8'h00);
            n_cmp++; if (pc_load_en !== 1'b1) begin n_fail++; $display("FAIL ovf_call%0d_strobe got %b want 1", i, pc_load_en); end
            tick();
        end
        n_cmp++; if (depth !== 4'd9 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full got depth=%0d ovf=%b want 9/0", depth, overflow); end
        issue(1'b1, 1'b0, 8'hA0, 8'hB0);
        n_cmp++; if ({overflow, pc_load_en, lr_load_en, ready} !== 4'b1001) begin n_fail++; $display("FAIL ovf_reject got %b want 1001", {overflow, pc_load_en, lr_load_en, ready}); end
        n_cmp++; if (depth !== 4'd9) begin n_fail++; $display("FAIL ovf_depth got %0d want 9", depth); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (depth !== 4'd0 || overflow !== 1'b1) begin n_fail++; $display("FAIL flush_idle got depth=%0d ovf=%b want 0/1", depth, overflow); end
        issue(1'b0, 1'b1, 8'h00, 8'h00);
        n_cmp++; if ({underflow, pc_load_en, lr_load_en, overflow} !== 4'b1001) begin n_fail++; $display("FAIL udf_reject got %b want 1001", {underflow, pc_load_en, lr_load_en, overflow}); end
        tick();
        n_cmp++; if (depth !== 4'd0 || underflow !== 1'b1) begin n_fail++; $display("FAIL udf_sticky got depth=%0d udf=%b want 0/1", depth, underflow); end
    endtask

    task automatic test_both_and_wrap();
        issue(1'b1, 1'b0, 8'h40, 8'h00); tick();
        issue(1'b1, 1'b0, 8'h41, 8'h00); tick();
        issue(1'b1, 1'b1, 8'h50, 8'h90);
        n_cmp++; if ({pc_next, lr_in, pc_load_en, lr_load_en} !== {8'h90, 8'h51, 2'b11}) begin n_fail++; $display("FAIL both_call got pc=%h lr=%h st=%b%b want 90 51 11", pc_next, lr_in, pc_load_en, lr_load_en); end
        tick();
        n_cmp++; if (depth !== 4'd3) begin n_fail++; $display("FAIL both_depth got %0d want 3", depth); end
        issue(1'b1, 1'b0, 8'hFF, 8'h05);
        n_cmp++; if ({lr_in, lr_load_en, pc_next} !== {8'h00, 1'b1, 8'h05}) begin n_fail++; $display("FAIL wrap got lr=%h ll=%b pc=%h want 00 1 05", lr_in, lr_load_en, pc_next); end
        tick();
        n_cmp++; if (depth !== 4'd4) begin n_fail++; $display("FAIL wrap_depth got %0d want 4", depth); end
    endtask

    task automatic test_reset_mid_call();
        issue(1'b1, 1'b0, 8'h12, 8'h34);
        n_cmp++; if (pc_load_en !== 1'b1) begin n_fail++; $display("FAIL rst_pre got %b want 1", pc_load_en); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({lr_in, pc_next, lr_load_en, pc_load_en} !== 18'h0) begin n_fail++; $display("FAIL rst_mid_out got %h want 0", {lr_in, pc_next, lr_load_en, pc_load_en}); end
        n_cmp++; if ({ready, depth, overflow, underflow} !== 7'b1000000) begin n_fail++; $display("FAIL rst_mid_status got %b want 1000000", {ready, depth, overflow, underflow}); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if ({lr_load_en, pc_load_en, ready} !== 3'b001) begin n_fail++; $display("FAIL rst_after got %b want 001", {lr_load_en, pc_load_en, ready}); end
    endtask

    task automatic test_flush_ret();
        issue(1'b1, 1'b0, 8'h20, 8'h80); tick();
        issue(1'b1, 1'b0, 8'h21, 8'h81); tick();
        issue(1'b0, 1'b1, 8'h00, 8'h00);
        flush = 1'b1;
        #1;
        n_cmp++; if ({pc_load_en, pc_next, lr_load_en, lr_in} !== {1'b1, 8'h22, 1'b1, 8'h21}) begin n_fail++; $display("FAIL flush_ret_strobe got %b %h %b %h want 1 22 1 21", pc_load_en, pc_next, lr_load_en, lr_in); end
        tick();
        flush = 1'b0;
        n_cmp++; if (depth !== 4'd0 || ready !== 1'b1) begin n_fail++; $display("FAIL flush_ret_depth got %0d/%b want 0/1", depth, ready); end
        // With sp cleared, a fresh single frame returns without a refill.
        issue(1'b1, 1'b0, 8'h60, 8'h70); tick();
        issue(1'b0, 1'b1, 8'h00, 8'h00);
        n_cmp++; if ({pc_next, lr_load_en} !== {8'h61, 1'b0}) begin n_fail++; $display("FAIL flush_sp got pc=%h ll=%b want 61 0", pc_next, lr_load_en); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_nested();
        test_overflow_underflow();
        test_both_and_wrap();
        test_reset_mid_call();
        test_flush_ret();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
